// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb
//  Purpose  : Arbitrates one single-port memory between the fetch stage and
//             the memory stage. Data accesses win ties, but a fetch that has
//             watched STARVE_MAX consecutive data grants is served next.
//             Every access is bounded by a TIMEOUT-cycle watchdog.
//  Ports    : clk, rst                       - clock, sync active-high reset
//             f_req/f_addr -> f_rdata/f_valid/f_err    fetch requester
//             m_req/m_we/m_addr/m_wdata -> m_rdata/m_valid/m_err  data side
//             F_stall_o, M_stall_o           - pipeline stall outputs
//             mem_en/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ready - memory
//  Revision : 1.0  initial release
// ============================================================================
module mem_arb #(
    parameter int TIMEOUT    = 255,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic [31:0] f_rdata,
    output logic        f_valid,
    output logic        f_err,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic [31:0] m_rdata,
    output logic        m_valid,
    output logic        m_err,
    output logic        F_stall_o,
    output logic        M_stall_o,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BUSY_D  = 2'd1;
    localparam logic [1:0] c_BUSY_F  = 2'd2;
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);
    localparam logic [3:0] c_STARVE  = 4'(STARVE_MAX);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_starve;
    logic [7:0]  r_wait;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_f_rdata;
    logic [31:0] r_m_rdata;
    logic        r_f_valid;
    logic        r_m_valid;
    logic        r_f_err;
    logic        r_m_err;

    logic w_idle;
    logic w_busy;
    logic w_done;
    logic w_forced;
    logic w_grant_d;
    logic w_grant_f;
    logic w_timeout;
    logic w_ready;
    logic w_finish;

    assign w_idle    = (r_state == c_IDLE);
    assign w_busy    = ~w_idle;
    // The cycle carrying a valid pulse never grants, so a requester that is
    // still holding req for the access just completed is not served twice.
    assign w_done    = r_f_valid | r_m_valid;
    assign w_forced  = (r_starve == c_STARVE) & f_req;
    assign w_grant_d = w_idle & ~w_done & m_req & ~w_forced;
    assign w_grant_f = w_idle & ~w_done & ~w_grant_d & f_req;
    // Timeout wins over a late mem_ready: the strobe is already withdrawn.
    assign w_timeout = w_busy & (r_wait == c_TIMEOUT);
    assign w_ready   = w_busy & ~w_timeout & mem_ready;
    assign w_finish  = w_ready | w_timeout;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and memory strobes
    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = c_BUSY_D;
                end else if (w_grant_f) begin
                    w_state_nxt = c_BUSY_F;
                end
            end
            c_BUSY_D: begin
                mem_en = ~w_timeout;
                mem_we = ~w_timeout & r_mem_we;
                if (w_finish) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_BUSY_F: begin
                mem_en = ~w_timeout;
                if (w_finish) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Access registers, wait/starve counters and completion reporting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve    <= 4'd0;
            r_wait      <= 8'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_f_rdata   <= 32'd0;
            r_m_rdata   <= 32'd0;
            r_f_valid   <= 1'b0;
            r_m_valid   <= 1'b0;
            r_f_err     <= 1'b0;
            r_m_err     <= 1'b0;
        end else begin
            r_f_valid <= 1'b0;
            r_m_valid <= 1'b0;
            r_f_err   <= 1'b0;
            r_m_err   <= 1'b0;

            if (w_grant_d) begin
                r_mem_addr  <= m_addr;
                r_mem_we    <= m_we;
                r_mem_wdata <= m_wdata;
                r_wait      <= 8'd0;
            end else if (w_grant_f) begin
                r_mem_addr  <= f_addr;
                r_mem_we    <= 1'b0;
                r_wait      <= 8'd0;
            end else if (w_busy && !w_finish) begin
                r_wait <= r_wait + 8'd1;
            end

            if (w_grant_f) begin
                r_starve <= 4'd0;
            end else if (w_grant_d && f_req) begin
                if (r_starve != c_STARVE) begin
                    r_starve <= r_starve + 4'd1;
                end
            end else if (w_idle && !f_req) begin
                r_starve <= 4'd0;
            end

            if (w_finish) begin
                if (r_state == c_BUSY_D) begin
                    r_m_valid <= 1'b1;
                    r_m_err   <= w_timeout;
                    if (w_timeout) begin
                        r_m_rdata <= 32'd0;
                    end else if (!r_mem_we) begin
                        r_m_rdata <= mem_rdata;
                    end
                end else begin
                    r_f_valid <= 1'b1;
                    r_f_err   <= w_timeout;
                    r_f_rdata <= w_timeout ? 32'd0 : mem_rdata;
                end
            end
        end
    end

    assign f_rdata   = r_f_rdata;
    assign f_valid   = r_f_valid;
    assign f_err     = r_f_err;
    assign m_rdata   = r_m_rdata;
    assign m_valid   = r_m_valid;
    assign m_err     = r_m_err;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign F_stall_o = f_req & ~r_f_valid;
    assign M_stall_o = m_req & ~r_m_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arb
//  Purpose  : Self-checking bench for mem_arb: directed scenarios followed by
//             randomized traffic against a transaction-level memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arb;

    localparam int TIMEOUT    = 8;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req;
    logic [31:0] f_addr;
    logic [31:0] f_rdata;
    logic        f_valid;
    logic        f_err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_valid;
    logic        m_err;
    logic        F_stall_o;
    logic        M_stall_o;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    mem_arb #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata),
        .f_valid(f_valid), .f_err(f_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_valid(m_valid), .m_err(m_err),
        .F_stall_o(F_stall_o), .M_stall_o(M_stall_o),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory content model: read data is a fixed function of the address.
    function automatic logic [31:0] rdfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic do_reset();
        rst = 1'b1; f_req = 1'b0; m_req = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_en(input string tag);
        int n = 0;
        while (!mem_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, mem_en}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got hang expected completion");
        $fatal(1, "watchdog expired");
    end

    // Random-phase scoreboard state
    bit          f_out, m_out, in_acc, acc_d, fv, mv;
    int          f_wait, m_wait, consec, acc_len, en_cnt, g, cyc;
    logic [31:0] last_m, exp_m;
    bit          owner [10];

    initial begin
        f_addr = 32'd0; m_we = 1'b0; m_addr = 32'd0; m_wdata = 32'd0;
        mem_rdata = 32'd0;
        rst = 1'b1; f_req = 1'b0; m_req = 1'b0; mem_ready = 1'b0;

        // ---------------- reset state ----------------
        @(negedge clk);
        check("rst_mem_en",    {31'd0, mem_en},  32'd0);
        check("rst_mem_we",    {31'd0, mem_we},  32'd0);
        check("rst_valids",    {30'd0, f_valid, m_valid}, 32'd0);
        check("rst_errs",      {30'd0, f_err, m_err},     32'd0);
        check("rst_f_rdata",   f_rdata,   32'd0);
        check("rst_m_rdata",   m_rdata,   32'd0);
        check("rst_mem_addr",  mem_addr,  32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ---------------- single fetch, minimum latency ----------------
        f_req = 1'b1; f_addr = 32'h10;
        #1 check("fetch_stall_c0", {31'd0, F_stall_o}, 32'd1);
        @(negedge clk);
        check("fetch_en",    {31'd0, mem_en}, 32'd1);
        check("fetch_addr",  mem_addr, 32'h10);
        check("fetch_we",    {31'd0, mem_we}, 32'd0);
        check("fetch_stall_c1", {31'd0, F_stall_o}, 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'h30F2_0500;
        @(negedge clk);
        mem_ready = 1'b0;
        check("fetch_valid", {31'd0, f_valid}, 32'd1);
        check("fetch_err",   {31'd0, f_err},   32'd0);
        check("fetch_rdata", f_rdata, 32'h30F2_0500);
        check("fetch_stall_c2", {31'd0, F_stall_o}, 32'd0);
        f_req = 1'b0;
        @(negedge clk);
        check("fetch_single_pulse", {31'd0, f_valid}, 32'd0);

        // ---------------- simultaneous requests: data first ----------------
        f_req = 1'b1; f_addr = 32'h24;
        m_req = 1'b1; m_we = 1'b1; m_addr = 32'h100; m_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("tie_en",    {31'd0, mem_en}, 32'd1);
        check("tie_we",    {31'd0, mem_we}, 32'd1);
        check("tie_addr",  mem_addr,  32'h100);
        check("tie_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_ready = 1'b0;
        check("tie_m_valid", {31'd0, m_valid}, 32'd1);
        check("tie_write_keeps_rdata", m_rdata, 32'd0);
        m_req = 1'b0;
        wait_en("tie_fetch_granted");
        check("tie_fetch_addr", mem_addr, 32'h24);
        check("tie_fetch_we",   {31'd0, mem_we}, 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        mem_ready = 1'b0;
        check("tie_f_valid", {31'd0, f_valid}, 32'd1);
        check("tie_f_rdata", f_rdata, 32'h0BAD_F00D);
        f_req = 1'b0;
        repeat (2) @(negedge clk);

        // ---------------- starvation limit ----------------
        f_req = 1'b1; f_addr = 32'h20;
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h8000_0040;
        g = 0; cyc = 0;
        while (g < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            mem_ready = 1'b0;
            if (mem_en) begin
                owner[g] = mem_addr[31];
                g++;
                mem_ready = 1'b1;
                mem_rdata = rdfn(mem_addr);
            end
        end
        check("starve_grant_count", g, 32'd10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("starve_grant%0d_is_data", i), {31'd0, owner[i]},
                  ((i % (STARVE_MAX + 1)) == STARVE_MAX) ? 32'd0 : 32'd1);
        end
        f_req = 1'b0; m_req = 1'b0;
        @(negedge clk);
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("starve_m_rdata", m_rdata, rdfn(32'h8000_0040));

        // ---------------- data timeout ----------------
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h200;
        en_cnt = 0; cyc = 0;
        while (!m_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_en) begin
                en_cnt++;
                if (en_cnt == 1) check("to_m_stall", {31'd0, M_stall_o}, 32'd1);
            end
        end
        check("to_en_cycles", en_cnt, TIMEOUT);
        check("to_m_valid",   {31'd0, m_valid}, 32'd1);
        check("to_m_err",     {31'd0, m_err},   32'd1);
        check("to_m_rdata",   m_rdata, 32'd0);
        check("to_m_stall_released", {31'd0, M_stall_o}, 32'd0);
        m_req = 1'b0;
        repeat (2) @(negedge clk);

        // ---------------- reset during second fetch BUSY cycle ----------------
        f_req = 1'b1; f_addr = 32'h44;
        wait_en("rst_busy_first");
        @(negedge clk);
        check("rst_busy_second", {31'd0, mem_en}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy_en_drop", {31'd0, mem_en},  32'd0);
        check("rst_busy_no_valid", {31'd0, f_valid}, 32'd0);
        rst = 1'b0;
        cyc = 0;
        while (!mem_en && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (f_valid) check("rst_busy_spurious_valid", {31'd0, f_valid}, 32'd0);
        end
        check("rst_busy_regrant", {31'd0, mem_en}, 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_ready = 1'b0;
        check("rst_busy_f_valid", {31'd0, f_valid}, 32'd1);
        check("rst_busy_f_rdata", f_rdata, 32'hCAFE_F00D);
        f_req = 1'b0;
        repeat (2) @(negedge clk);

        // ---------------- requester drops req mid-access ----------------
        f_req = 1'b1; f_addr = 32'h80;
        wait_en("drop_grant");
        f_req = 1'b0;
        @(negedge clk);
        check("drop_still_busy", {31'd0, mem_en}, 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        mem_ready = 1'b0;
        check("drop_f_valid", {31'd0, f_valid}, 32'd1);
        check("drop_f_rdata", f_rdata, 32'h1357_9BDF);

        // ---------------- randomized traffic ----------------
        do_reset();
        last_m = 32'd0; consec = 0; in_acc = 1'b0; acc_len = 0;
        f_out = 1'b0; m_out = 1'b0; f_wait = 0; m_wait = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            fv = f_valid; mv = m_valid;
            check("rnd_f_stall", {31'd0, F_stall_o}, {31'd0, f_out & ~fv});
            check("rnd_m_stall", {31'd0, M_stall_o}, {31'd0, m_out & ~mv});
            if (fv) begin
                check("rnd_f_pending", {31'd0, f_out}, 32'd1);
                check("rnd_f_err",     {31'd0, f_err}, 32'd0);
                check("rnd_f_rdata",   f_rdata, rdfn(f_addr));
                check("rnd_f_latency", {31'd0, f_wait <= 80}, 32'd1);
                f_out = 1'b0; f_req = 1'b0;
            end
            if (mv) begin
                exp_m = m_we ? last_m : rdfn(m_addr);
                check("rnd_m_pending", {31'd0, m_out}, 32'd1);
                check("rnd_m_err",     {31'd0, m_err}, 32'd0);
                check("rnd_m_rdata",   m_rdata, exp_m);
                check("rnd_m_latency", {31'd0, m_wait <= 80}, 32'd1);
                last_m = exp_m;
                m_out = 1'b0; m_req = 1'b0;
            end

            mem_ready = 1'b0;
            mem_rdata = $urandom;
            if (mem_en) begin
                if (!in_acc) begin
                    in_acc = 1'b1; acc_len = 0; acc_d = mem_addr[31];
                    if (acc_d) begin
                        check("rnd_d_grant_pending", {31'd0, m_out}, 32'd1);
                        check("rnd_d_addr", mem_addr, m_addr);
                        check("rnd_d_we",   {31'd0, mem_we}, {31'd0, m_we});
                        if (m_we) check("rnd_d_wdata", mem_wdata, m_wdata);
                        if (f_out) begin
                            consec++;
                            check("rnd_starve_bound", {31'd0, consec <= STARVE_MAX}, 32'd1);
                        end else begin
                            consec = 0;
                        end
                    end else begin
                        check("rnd_fetch_grant_pending", {31'd0, f_out}, 32'd1);
                        check("rnd_fetch_addr", mem_addr, f_addr);
                        check("rnd_fetch_we",   {31'd0, mem_we}, 32'd0);
                        consec = 0;
                    end
                end
                if (acc_len >= 4 || $urandom_range(1, 0) == 1) begin
                    mem_ready = 1'b1;
                    mem_rdata = rdfn(mem_addr);
                    in_acc = 1'b0;
                end
                acc_len++;
            end else begin
                // Stray ready pulses while idle must be ignored.
                mem_ready = ($urandom_range(3, 0) == 0);
            end

            if (f_out) f_wait++;
            if (m_out) m_wait++;
            if (!f_out && !fv && $urandom_range(2, 0) == 0) begin
                f_out = 1'b1; f_wait = 0; f_req = 1'b1;
                f_addr = {1'b0, 29'($urandom), 2'b00};
            end
            if (!m_out && !mv && $urandom_range(2, 0) == 0) begin
                m_out = 1'b1; m_wait = 0; m_req = 1'b1;
                m_we = 1'($urandom);
                m_addr = {1'b1, 29'($urandom), 2'b00};
                m_wdata = $urandom;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter: TIMEOUT, 255, max cycles a memory access may wait for mem_ready before the arbiter aborts it (1..255).
REQ-002 Parameter: STARVE_MAX, 4, consecutive data grants allowed while fetch waits before fetch is forced first (1..15).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 f_req  input  1  fetch-stage read request; held with f_addr until f_valid.
REQ-006 f_addr  input  32  fetch byte address.
REQ-007 f_rdata  output  32  fetch read data; meaningful only while f_valid.
REQ-008 f_valid  output  1  one-cycle pulse completing a fetch access.
REQ-009 f_err  output  1  with f_valid: access timed out (stage reports ADR status).
REQ-010 m_req  input  1  memory-stage request; held with m_we/m_addr/m_wdata until m_valid.
REQ-011 m_we  input  1  1 = write (rmmovl/pushl/call), 0 = read.
REQ-012 m_addr  input  32  data byte address.
REQ-013 m_wdata  input  32  write data.
REQ-014 m_rdata  output  32  data read result; meaningful only while m_valid.
REQ-015 m_valid  output  1  one-cycle pulse completing a data access.
REQ-016 m_err  output  1  with m_valid: access timed out.
REQ-017 F_stall_o  output  1  stall fetch/decode registers.
REQ-018 M_stall_o  output  1  stall ex_mem/mem_wb registers.
REQ-019 mem_en  output  1  access strobe to the single-port memory.
REQ-020 mem_we  output  1  write enable to memory.
REQ-021 mem_addr  output  32  memory address.
REQ-022 mem_wdata  output  32  memory write data.
REQ-023 mem_rdata  input  32  memory read data, valid with mem_ready.
REQ-024 mem_ready  input  1  memory completes the current access this cycle.

Function
REQ-025 The block SHALL implement states IDLE, BUSY_D (data access), BUSY_F (fetch access).
REQ-026 IDLE: m_req and not forced-fetch -> BUSY_D; else f_req -> BUSY_F; else stay; grant decided combinationally, state registered at the edge.
REQ-027 Forced-fetch SHALL be true when starve count == STARVE_MAX and f_req high.
REQ-028 Starve count (4-bit) SHALL increment, saturating at STARVE_MAX, on each BUSY_D entry while f_req high; clear on BUSY_F entry or when f_req low in IDLE.
REQ-029 In BUSY_*: mem_en=1; mem_addr/mem_we/mem_wdata SHALL come from registers loaded at grant, stable for the whole access; mem_we=0 in BUSY_F.
REQ-030 BUSY_*: mem_ready=1 -> capture mem_rdata into the owner's rdata register, pulse owner's valid next cycle with err=0, return to IDLE.
REQ-031 Minimum latency request-to-valid SHALL be 2 cycles (mem_ready in first BUSY cycle); next grant earliest the cycle after valid.
REQ-032 8-bit wait counter SHALL clear on BUSY entry and increment each BUSY cycle without mem_ready; at count == TIMEOUT: mem_en drops, owner valid and err pulse, rdata=0, return to IDLE.
REQ-033 mem_ready in IDLE SHALL be ignored.
REQ-034 F_stall_o = f_req & ~f_valid; M_stall_o = m_req & ~m_valid (combinational).
REQ-035 A requester dropping req mid-access SHALL NOT abort it; the access completes and valid still pulses.
REQ-036 Writes SHALL return m_rdata unchanged from prior value.

Reset
REQ-037 On rst: state IDLE; mem_en, mem_we, f_valid, m_valid, f_err, m_err = 0; f_rdata, m_rdata, mem_addr, mem_wdata = 0; counters = 0.
REQ-038 rst during BUSY SHALL drop mem_en at that edge; no valid pulse for the killed access.

Verification
REQ-039 f_req only, f_addr=0x10, mem_ready 1st BUSY cycle, mem_rdata=0x30F20500 -> f_valid 2 cycles after request, f_rdata=0x30F20500, F_stall_o high 2 cycles.
REQ-040 f_req and m_req same cycle (m_we=1, m_addr=0x100, m_wdata=0xDEADBEEF) -> mem_we=1 @0x100 first, m_valid, then fetch granted.
REQ-041 m_req held continuously with f_req, STARVE_MAX=4 -> exactly 4 data grants then 1 fetch grant, repeating.
REQ-042 BUSY_D, mem_ready never asserted, TIMEOUT=8 -> mem_en high 8 cycles, m_valid=m_err=1, m_rdata=0.
REQ-043 rst in 2nd BUSY_F cycle -> mem_en=0 next cycle, no f_valid, state IDLE, fresh f_req granted normally.
